// File: rtl/mips_defs.sv
// Shared MIPS multiply/divide definitions: opcode encodings, FSM state codes and datapath width.
package mips_defs;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; serves as abs() on operands and as the
// sign restore on product, quotient and remainder.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply, restoring
// divide, sign fix-up and architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start_i; MTHI/MTLO writes accepted
// MUL   | one shift-add iteration per clock
// DIV   | one restoring shift-subtract iteration per clock
// FIX   | sign correction, HI/LO write, done_o pulse
module mult_div_unit #(
  parameter int DATA_WIDTH = mips_defs::DATA_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  hi_we_i,
  input  logic                  lo_we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  import mips_defs::*;

  localparam int W = DATA_WIDTH;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                 is_div_q, is_div_d, dz_q, dz_d;
  logic                 done_q, done_d, dzo_q, dzo_d;

  logic                 is_signed;
  logic [W-1:0]         a_mag, b_mag;
  logic [2*W-1:0]       prod_res;
  logic [W-1:0]         quo_res, rem_res;
  logic [W:0]           mul_sum, div_shift, div_diff;
  logic [2*W-1:0]       mul_next, div_next;

  assign is_signed = ~op_i[0];

  mdu_sign_fix #(.W(W))   u_abs_a (.val_i(a_i), .neg_i(is_signed & a_i[W-1]), .res_o(a_mag));
  mdu_sign_fix #(.W(W))   u_abs_b (.val_i(b_i), .neg_i(is_signed & b_i[W-1]), .res_o(b_mag));
  mdu_sign_fix #(.W(2*W)) u_prod  (.val_i(acc_q), .neg_i(neg_lo_q), .res_o(prod_res));
  mdu_sign_fix #(.W(W))   u_quo   (.val_i(acc_q[W-1:0]), .neg_i(neg_lo_q), .res_o(quo_res));
  mdu_sign_fix #(.W(W))   u_rem   (.val_i(acc_q[2*W-1:W]), .neg_i(neg_hi_q), .res_o(rem_res));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d    = CNT_WIDTH'(W - 1);
          is_div_d = op_i[1];
          neg_lo_d = is_signed & (a_i[W-1] ^ b_i[W-1]);
          dz_d     = 1'b0;
          if (op_i[1]) begin
            opnd_d   = b_mag;
            acc_d    = {{W{1'b0}}, a_mag};
            neg_hi_d = is_signed & a_i[W-1];
            if (b_i == '0) begin
              dz_d    = 1'b1;
              state_d = ST_FIX;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            opnd_d   = a_mag;
            acc_d    = {{W{1'b0}}, b_mag};
            neg_hi_d = is_signed & (a_i[W-1] ^ b_i[W-1]);
            state_d  = ST_MUL;
          end
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        dzo_d   = dz_q;
        state_d = ST_IDLE;
        if (!dz_q) begin
          if (is_div_q) begin
            lo_d = quo_res;
            hi_d = rem_res;
          end else begin
            {hi_d, lo_d} = prod_res;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign div_zero_o = dzo_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, divide-by-zero,
// busy-time input masking and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0, b_i = '0;
  logic        hi_we_i = 1'b0, lo_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // lat = edges after the start edge at which done_o is seen (bounded at 60).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic dz);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; op_i = ~op; a_i = 32'h1234_5678; b_i = 32'h0;
    lat = 0;
    busy_cnt = busy_o ? 1 : 0;
    while (!done_o && lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy_o) busy_cnt++;
    end
    dz = div_zero_o;
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk);
    hi_we_i = 1'b1; wdata_i = hv;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b1; wdata_i = lv;
    @(negedge clk);
    lo_we_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({busy_o, done_o, div_zero_o} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {busy_o, done_o, div_zero_o});
    end
    tests++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      fails++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi_o, lo_o);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int lat, bc; logic dz;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc, dz);
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL mult_latency: got %0d want 33", lat); end
    tests++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFEB) begin
      fails++; $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb", hi_o, lo_o);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b want 0", done_o); end
  endtask

  task automatic test_multu();
    int lat, bc; logic dz;
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat, bc, dz);
    tests++;
    if (bc !== 33) begin fails++; $display("FAIL multu_busy: got %0d want 33", bc); end
    tests++;
    if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", hi_o, lo_o);
    end
  endtask

  task automatic test_div();
    int lat, bc; logic dz;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
    tests++;
    if (lat !== 33 || dz !== 1'b0) begin
      fails++; $display("FAIL div_timing: got lat=%0d dz=%b want 33/0", lat, dz);
    end
    tests++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div_signed: got lo=%h hi=%h want fffffffd/ffffffff", lo_o, hi_o);
    end
    run_op(2'b11, 32'd100, 32'd7, lat, bc, dz);
    tests++;
    if (lo_o !== 32'd14 || hi_o !== 32'd2) begin
      fails++; $display("FAIL divu: got lo=%0d hi=%0d want 14/2", lo_o, hi_o);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
    tests++;
    if (lo_o !== 32'h8000_0000 || hi_o !== 32'h0) begin
      fails++; $display("FAIL div_overflow: got lo=%h hi=%h want 80000000/0", lo_o, hi_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic dz;
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, lat, bc, dz);
    tests++;
    if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
      fails++; $display("FAIL b2b_multu: got %h_%h want 00000001_00000000", hi_o, lo_o);
    end
    run_op(2'b10, 32'hFFFF_FFEC, 32'd3, lat, bc, dz);
    tests++;
    if (lat !== 33 || lo_o !== 32'hFFFF_FFFA || hi_o !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL b2b_div: got lat=%0d lo=%h hi=%h want 33/fffffffa/fffffffe", lat, lo_o, hi_o);
    end
    run_op(2'b10, 32'd20, 32'hFFFF_FFFD, lat, bc, dz);
    tests++;
    if (lo_o !== 32'hFFFF_FFFA || hi_o !== 32'd2) begin
      fails++; $display("FAIL div_neg_divisor: got lo=%h hi=%h want fffffffa/00000002", lo_o, hi_o);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic dz;
    write_hilo(32'h11, 32'h22);
    tests++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      fails++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want 11/22", hi_o, lo_o);
    end
    run_op(2'b11, 32'd5, 32'd0, lat, bc, dz);
    tests++;
    if (lat !== 1 || dz !== 1'b1) begin
      fails++; $display("FAIL divzero_flag: got lat=%0d dz=%b want 1/1", lat, dz);
    end
    tests++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      fails++; $display("FAIL divzero_hilo: got hi=%h lo=%h want 11/22", hi_o, lo_o);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0 || div_zero_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL divzero_pulse: got done=%b dz=%b busy=%b want 0/0/0", done_o, div_zero_o, busy_o);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd4;
    lat = 0;
    while (!done_o && lat < 60) begin
      @(negedge clk);
      if (lat == 9) begin
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd0;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hAA;
      end else begin
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      end
      if (lat > 0 || done_o) lat = lat;
      lat++;
    end
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    tests++;
    if (lat !== 34 || div_zero_o !== 1'b0) begin
      fails++; $display("FAIL busy_ignore_timing: got lat=%0d dz=%b want 34/0", lat - 1, div_zero_o);
    end
    tests++;
    if (hi_o !== 32'h0 || lo_o !== 32'd12) begin
      fails++; $display("FAIL busy_ignore_result: got hi=%h lo=%h want 0/c", hi_o, lo_o);
    end
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL busy_no_queue: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      fails++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy_o, hi_o, lo_o);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen); end
    lo_we_i = 1'b1; wdata_i = 32'h55;
    @(negedge clk);
    lo_we_i = 1'b0;
    tests++;
    if (lo_o !== 32'h55 || hi_o !== 32'h0) begin
      fails++; $display("FAIL mtlo_after_reset: got lo=%h hi=%h want 55/0", lo_o, hi_o);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_back_to_back();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multi-cycle multiply/divide unit for the MIPS core, paired with the single-cycle ALU for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Accepts operands and an opcode via a start/busy/done handshake.
- Runs a 32-step shift-add (multiply) or restoring (divide) sequence.
- Holds results in architectural HI/LO registers.
- The control unit stalls the pipeline while busy_o is high.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width
CNT_WIDTH, 5, iteration counter width (log2 DATA_WIDTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start_i  input  1  request; sampled only when busy_o=0
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_i  input  32  rs operand (multiplicand / dividend)
b_i  input  32  rt operand (multiplier / divisor)
hi_we_i  input  1  MTHI write strobe
lo_we_i  input  1  MTLO write strobe
wdata_i  input  32  MTHI/MTLO data
busy_o  output  1  operation in progress
done_o  output  1  one-cycle completion pulse
div_zero_o  output  1  divisor was zero; valid with done_o
hi_o  output  32  HI register (MFHI source)
lo_o  output  32  LO register (MFLO source)

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE; counter=0.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0, all immediately.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start_i=1 at edge N:
  - Latch operand magnitudes (two's-complement absolute value for MULT/DIV; raw for MULTU/DIVU).
  - Latch result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - Go to MUL or DIV; busy_o=1 after edge N.
- MUL: 32 shift-add iterations over a 64-bit accumulator, one per edge (N+1..N+32), then FIX.
- DIV: 32 restoring shift-subtract iterations (N+1..N+32), then FIX.
- FIX (edge N+33):
  - Apply sign correction (negate product / quotient / remainder as latched).
  - Write HI/LO: MUL writes HI=upper, LO=lower. DIV writes LO=quotient, HI=remainder.
  - Same edge: busy_o->0, done_o->1 for exactly one cycle; return to IDLE.
- Latency: start at edge N -> HI/LO valid and done_o=1 after edge N+33.
- Divide by zero (DIV/DIVU with b_i=0):
  - No iterations; FIX taken at edge N+1.
  - HI/LO unchanged; done_o=1 and div_zero_o=1 for one cycle after N+1.
- Signed divide 0x80000000 / 0xFFFFFFFF: result wraps, LO=0x80000000, HI=0; no trap.
- start_i while busy_o=1: ignored, with no queuing.
- hi_we_i / lo_we_i:
  - Honoured only in IDLE with start_i=0: HI/LO <= wdata_i at the edge.
  - Ignored while busy.
  - start_i has priority over simultaneous writes.
- op_i, a_i, b_i: sampled only at the start edge; later changes have no effect.
- Reset mid-operation: aborts immediately; HI/LO cleared to 0; no done_o pulse.
- done_o and div_zero_o are registered outputs; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package/include mips_defs: op_i encodings (MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11), FSM state encodings, DATA_WIDTH.
- One natural sub-module: mdu_sign_fix, a combinational abs-value/negate helper used for the operand magnitudes and in FIX.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done_o 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE; busy_o high exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=5, b=0 with prior HI=0x11, LO=0x22 -> after 1 cycle done_o=1, div_zero_o=1; HI/LO unchanged.
- Start MULT 3*4; at cycle 10 pulse start_i with DIV ops and hi_we_i=1, wdata_i=0xAA -> both ignored; final HI=0, LO=12.
- Start DIV 100/7; assert reset at cycle 15 -> busy_o=0, HI=LO=0 immediately, no done_o. After release, MTLO 0x55 -> lo_o=0x55 next cycle.
